// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter and setup/enable/hold sequencer for a shared level-sensitive latch word.
// Optional protocol checker enabled by defining LAT_ERR_CHK_EN; otherwise o_err is tied low.
module latch_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_din,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_ack,
  output logic [DW-1:0]       o_lat_d,
  output logic                o_lat_en,
  output logic                o_busy,
  output logic                o_err
);

  localparam int MAX_SE = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAXC   = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [IW-1:0]     r_win;
  logic [IW-1:0]     w_win_nxt;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_cand;
  logic              w_any;
  logic [DW-1:0]     w_din_win;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  w_gnt_nxt;
  logic [N_REQ-1:0]  r_ack;
  logic [N_REQ-1:0]  w_ack_nxt;
  logic [DW-1:0]     r_lat_d;
  logic [DW-1:0]     w_lat_d_nxt;
  logic              r_lat_en;
  logic              w_lat_en_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_err;
  logic              w_err_nxt;

  // Scan from highest offset down so the lowest offset from the pointer wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % N_REQ);
      if (i_req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end else begin
        w_any = w_any;
      end
    end
  end

  always_comb begin
    w_din_win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == w_win) begin
        w_din_win = i_din[i*DW +: DW];
      end else begin
        w_din_win = w_din_win;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and phase counter
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next_state = S_SETUP;
          w_cnt_nxt    = CW'(SETUP_CYC - 1);
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_next_state = S_ENABLE;
          w_cnt_nxt    = CW'(EN_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_ENABLE: begin
        if (r_cnt == '0) begin
          w_next_state = S_HOLD;
          w_cnt_nxt    = CW'(HOLD_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_cnt_nxt    = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so every output leaves a flop.
  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_lat_d_nxt = r_lat_d;
    w_win_nxt   = r_win;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
          w_lat_d_nxt = w_din_win;
          w_win_nxt   = w_win;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      S_DONE: begin
        w_gnt_nxt = '0;
        w_ptr_nxt = IW'((int'(r_win) + 1) % N_REQ);
      end
      default: begin
        w_gnt_nxt = r_gnt;
      end
    endcase
    w_lat_en_nxt = (w_next_state == S_ENABLE);
    w_ack_nxt    = (w_next_state == S_DONE) ? r_gnt : '0;
    w_busy_nxt   = (w_next_state != S_IDLE);
  end

`ifdef LAT_ERR_CHK_EN
  logic [DW-1:0] w_din_cur;

  always_comb begin
    w_din_cur = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == r_win) begin
        w_din_cur = i_din[i*DW +: DW];
      end else begin
        w_din_cur = w_din_cur;
      end
    end
  end

  // Sticky flag: granted request dropped mid-transaction or data moved while transparent.
  always_comb begin
    w_err_nxt = r_err;
    case (r_state)
      S_SETUP, S_HOLD: begin
        if (!i_req[r_win]) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
      end
      S_ENABLE: begin
        if (!i_req[r_win] || (w_din_cur != r_lat_d)) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
      end
      default: begin
        w_err_nxt = r_err;
      end
    endcase
  end
`else
  assign w_err_nxt = 1'b0;
`endif

  // Output and arbitration registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt    <= '0;
      r_ack    <= '0;
      r_lat_d  <= '0;
      r_lat_en <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_ptr    <= '0;
      r_win    <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_ack    <= w_ack_nxt;
      r_lat_d  <= w_lat_d_nxt;
      r_lat_en <= w_lat_en_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
      r_ptr    <= w_ptr_nxt;
      r_win    <= w_win_nxt;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_ack    = r_ack;
  assign o_lat_d  = r_lat_d;
  assign o_lat_en = r_lat_en;
  assign o_busy   = r_busy;
  assign o_err    = r_err;

endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Round-robin write arbiter and timing sequencer for a shared level-sensitive D-latch storage word. Accepts write requests from N_REQ requesters, selects one, drives the latch data bus, and generates the latch enable with programmable setup, enable-width and hold phases so data is stable across the transparent window. A per-requester ACK signals capture completion. Sits between requesting logic and the gate-level latch bank (D/CLK inputs of the latch cells).

## Interface

- N_REQ, 4: number of requesters, 2..8
- DW, 8: latch word width
- SETUP_CYC, 1: cycles LAT_D is stable before LAT_EN rises, ≥1
- EN_CYC, 2: cycles LAT_EN is high, ≥1
- HOLD_CYC, 1: cycles LAT_D is held after LAT_EN falls, ≥1

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  N_REQ  per-requester write request, level
- DIN  in  N_REQ*DW  write data; requester i owns bits [i*DW +: DW]
- GNT  out  N_REQ  one-hot grant
- ACK  out  N_REQ  one-cycle completion pulse to granted requester
- LAT_D  out  DW  data to latch D inputs
- LAT_EN  out  1  latch enable (drives latch CLK)
- BUSY  out  1  high in any state except IDLE
- ERR  out  1  sticky protocol-error flag (LAT_ERR_CHK_EN only; tied 0 otherwise)

## Operation

- States: IDLE, SETUP, ENABLE, HOLD, DONE; down-counter CNT, width clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC)+1).
- Reset: state IDLE, GNT=0, ACK=0, LAT_D=0, LAT_EN=0, BUSY=0, ERR=0, priority pointer PTR=0.
- IDLE: if any REQ high, winner = first high REQ searching PTR, PTR+1, …, wrapping modulo N_REQ. Register GNT=onehot(winner), LAT_D=DIN[winner]; CNT=SETUP_CYC-1; go SETUP. No REQ: stay.
- SETUP: LAT_EN=0; CNT==0 → ENABLE, CNT=EN_CYC-1; else decrement.
- ENABLE: LAT_EN=1; CNT==0 → HOLD, CNT=HOLD_CYC-1.
- HOLD: LAT_EN=0, LAT_D unchanged; CNT==0 → DONE.
- DONE: ACK[winner]=1 for exactly this cycle; GNT held; next IDLE with GNT=0, PTR=(winner+1) mod N_REQ.
- LAT_D is captured once at grant; DIN changes afterward are ignored. LAT_D holds its last value in IDLE.
- LAT_EN is a registered output, glitch-free; never high outside ENABLE.
- Requester must hold REQ until ACK and drop it by the edge ending the ACK cycle; REQ still high in the following IDLE cycle is a new request.
- REQ dropped by the granted requester before ACK: transaction still completes with captured data; ACK still issued.
- REQ from non-granted requesters during a transaction: ignored until IDLE.
- RST asserted mid-transaction: immediate return to reset values, LAT_EN forced 0 asynchronously, no ACK.

## Timing

- Let grant edge = t0 (GNT rises). LAT_EN high for cycles t0+SETUP_CYC … t0+SETUP_CYC+EN_CYC-1.
- ACK high in cycle t0+SETUP_CYC+EN_CYC+HOLD_CYC.
- REQ-to-GNT latency: 1 cycle from IDLE.
- Back-to-back: next GNT earliest at t0+SETUP_CYC+EN_CYC+HOLD_CYC+2 (one IDLE cycle between transactions).
- Defaults: GNT→ACK = 4 cycles, transaction period 6 cycles.

## Configuration

- LAT_ERR_CHK_EN defined: ERR set (sticky until RST) when the granted requester's REQ is low in any SETUP, ENABLE or HOLD cycle, or when DIN of the granted requester differs from LAT_D during ENABLE. Transaction behaviour otherwise unchanged.
- Undefined: no check logic; ERR tied 0.

## Test plan

- Single request: REQ=0001, DIN[0]=0xA5 → GNT=0001 next cycle, LAT_D=0xA5, LAT_EN high exactly cycles t0+1, t0+2, ACK[0] at t0+4, BUSY low at t0+5.
- Round-robin: REQ=1111 held, each requester dropping after its ACK → grant order 0,1,2,3,0; 6-cycle spacing between GNT edges.
- Pointer wrap: PTR=3 after grant to 2, REQ=0101 → grant goes to 0, then 2.
- DIN changed to 0x3C after grant to requester 1 → LAT_D stays original value through HOLD; with LAT_ERR_CHK_EN, change during ENABLE sets ERR=1.
- Early REQ drop during ENABLE → ACK still issued at t0+4; ERR=1 only when LAT_ERR_CHK_EN defined.
- RST pulsed during ENABLE → LAT_EN=0, GNT=0, LAT_D=0 immediately, no ACK; after release next request granted from PTR=0.
